// File: rtl/data_mem_responder.sv
// data_mem_responder: single-cycle data-port responder with word RAM and an I/O window
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   mem_write  processor write strobe
//   addr       processor byte address
//   write_data processor store data
//   read_data  combinational load data for addr
//   out_data   FIFO head word to the consumer
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts out_data on this edge
//   err        sticky error flag
module data_mem_responder #(
    parameter int               WIDTH      = 22,
    parameter int               DEPTH      = 256,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [WIDTH-1:0] IO_BASE    = 22'h3FFF00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [FW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
    logic [FW:0]      count_q, count_d;
    logic [WIDTH-1:0] cycles_q, out_data_q, out_data_d, off, status;
    logic             err_q, err_d, out_valid_q;
    logic             is_io, mis, in_ram, known, wen, wr_ram, wr_tx, wr_clr;
    logic             full, empty, push, pop, new_err;

    always_comb begin
        off     = addr - IO_BASE;
        is_io   = addr >= IO_BASE;
        mis     = addr[1:0] != 2'b00;
        in_ram  = addr[WIDTH-1:AW+2] == '0;
        known   = off == WIDTH'(0) || off == WIDTH'(4) || off == WIDTH'(8) || off == WIDTH'(12);
        full    = count_q == (FW+1)'(FIFO_DEPTH);
        empty   = count_q == '0;
        status  = WIDTH'({err_q, full, empty, count_q});
        read_data = mis ? '0 :
                    !is_io ? (in_ram ? ram[addr[AW+1:2]] : '0) :
                    off == WIDTH'(4) ? status :
                    off == WIDTH'(8) ? cycles_q : '0;
        // Writes during reset are ignored entirely, including their error side effects.
        wen     = mem_write & rst & !mis;
        wr_ram  = wen & !is_io & in_ram;
        wr_tx   = wen & is_io & off == WIDTH'(0);
        wr_clr  = wen & is_io & off == WIDTH'(12);
        pop     = out_valid_q & out_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
        push    = wr_tx & (!full | pop);
        // Writes to the read-only STATUS/CYCLES offsets are dropped silently.
        new_err = (mem_write & rst & (mis | (!is_io & !in_ram) | (is_io & !known))) |
                  (wr_tx & full & !pop);
        err_d   = new_err | (err_q & !wr_clr);
        wptr_d  = wptr_q + FW'(push);
        rptr_d  = rptr_q + FW'(pop);
        count_d = count_q + (FW+1)'(push) - (FW+1)'(pop);
        // Head register: next entry on pop, or the pushed word when it lands in an empty slot.
        out_data_d = pop ? (count_q > (FW+1)'(1) ? fifo_q[rptr_q + FW'(1)] :
                            push ? write_data : out_data_q) :
                     (push & empty) ? write_data : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_ram) ram[addr[AW+1:2]] <= write_data;
        if (push) fifo_q[wptr_q] <= write_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            cycles_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            cycles_q    <= cycles_q + WIDTH'(1);
            out_data_q  <= out_data_d;
            out_valid_q <= count_d != '0;
            err_q       <= err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder
module tb_data_mem_responder;
    localparam logic [21:0] TX  = 22'h3FFF00;
    localparam logic [21:0] ST  = 22'h3FFF04;
    localparam logic [21:0] CY  = 22'h3FFF08;
    localparam logic [21:0] CLR = 22'h3FFF0C;

    logic        clk = 0, rst = 0, mem_write = 0, out_ready = 0;
    logic [21:0] addr = 0, write_data = 0;
    logic [21:0] read_data, out_data;
    logic        out_valid, err;
    int          total = 0, bad = 0;
    logic [21:0] exp_q [$];

    data_mem_responder dut (
        .clk(clk), .rst(rst), .mem_write(mem_write), .addr(addr),
        .write_data(write_data), .read_data(read_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected got=%h required=none", out_data);
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL pop_data got=%h required=%h", out_data, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [21:0] act, input logic [21:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", n, act, req);
        end
    endtask

    task automatic wr(input logic [21:0] a, input logic [21:0] d);
        addr = a;
        write_data = d;
        mem_write = 1;
        cyc();
        mem_write = 0;
    endtask

    task automatic push(input logic [21:0] d);
        exp_q.push_back(d);
        wr(TX, d);
    endtask

    task automatic rd(input string n, input logic [21:0] a, input logic [21:0] req);
        addr = a;
        mem_write = 0;
        #1;
        chk(n, read_data, req);
    endtask

    task automatic drain(input string n);
        out_ready = 1;
        for (int i = 0; i < 20 && out_valid; i++) cyc();
        chk(n, {21'd0, out_valid}, 22'd0);
        chk({n, "_queue"}, 22'(exp_q.size()), 22'd0);
        out_ready = 0;
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_valid", {21'd0, out_valid}, 22'd0);
        chk("rst_err", {21'd0, err}, 22'd0);
        chk("rst_out_data", out_data, 22'd0);
        rd("rst_status", ST, 22'h10);
        rst = 1;

        wr(22'h14, 22'h0ABCD);
        wr(22'h10, 22'h12345);
        rd("ram_10", 22'h10, 22'h12345);
        rd("ram_14", 22'h14, 22'h0ABCD);
        wr(22'h20, 22'h00111);
        addr = 22'h20; write_data = 22'h00222; mem_write = 1; #1;
        chk("ram_old_word", read_data, 22'h00111);
        cyc();
        mem_write = 0;
        rd("ram_new_word", 22'h20, 22'h00222);

        addr = TX; write_data = 22'h0AAAA; mem_write = 1; exp_q.push_back(22'h0AAAA); #1;
        chk("push_not_visible", {21'd0, out_valid}, 22'd0);
        cyc();
        mem_write = 0;
        chk("push_visible", {21'd0, out_valid}, 22'd1);
        push(22'h0BBBB);
        push(22'h0CCCC);
        rd("status_3", ST, 22'h03);
        chk("head_a", out_data, 22'h0AAAA);
        drain("drain_abc");

        for (int i = 0; i < 8; i++) push(22'h100 + 22'(i));
        rd("status_full", ST, 22'h28);
        wr(TX, 22'h3FFFF);
        chk("overflow_err", {21'd0, err}, 22'd1);
        rd("status_full_err", ST, 22'h68);
        wr(CLR, 22'd0);
        chk("errclr", {21'd0, err}, 22'd0);

        out_ready = 1;
        push(22'h02222);
        out_ready = 0;
        chk("full_pushpop_err", {21'd0, err}, 22'd0);
        rd("full_pushpop_status", ST, 22'h28);
        drain("drain_full");

        wr(22'h1, 22'h05555);
        chk("misaligned_err", {21'd0, err}, 22'd1);
        rd("misaligned_rd", 22'h1, 22'd0);
        wr(CLR, 22'd0);
        wr(22'h400, 22'h06666);
        chk("range_err", {21'd0, err}, 22'd1);
        rd("range_rd", 22'h400, 22'd0);
        rd("ram_10_kept", 22'h10, 22'h12345);
        wr(CLR, 22'd0);
        wr(22'h3FFF10, 22'h1);
        chk("bad_io_err", {21'd0, err}, 22'd1);
        wr(CLR, 22'd0);

        push(22'h0DEAD);
        push(22'h0BEEF);
        rst = 0;
        wr(TX, 22'h07777);
        exp_q.delete();
        chk("reset_valid", {21'd0, out_valid}, 22'd0);
        chk("reset_out_data", out_data, 22'd0);
        rd("reset_status", ST, 22'h10);
        rd("reset_cycles", CY, 22'd0);
        rst = 1;
        cyc();
        rd("cycles_one", CY, 22'd1);
        rd("ram_after_reset", 22'h10, 22'h12345);
        chk("final_queue", 22'(exp_q.size()), 22'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
